// File: rtl/eth_rx_frame_ctrl.sv
// Receive frame sequencer: MII byte stream into a slotted frame buffer.
// Commits or discards each frame and hands committed slots to the parser in order.
module eth_rx_frame_ctrl #(
   parameter  int P_SLOTS   = 4,
   parameter  int P_VLD_WIN = 8,
   parameter  int P_MIN_LEN = 64,
   localparam int SLOT_W    = $clog2(P_SLOTS)
) (
   input  logic              rx_clk,
   input  logic              rx_rst_n,
   input  logic              rx_sof,
   input  logic              rx_eof,
   input  logic              rx_byte_vld,
   input  logic [7:0]        rx_byte,
   input  logic              rx_frm_vld,
   output logic              rx_frm_ack,
   output logic              buf_we,
   output logic [SLOT_W+10:0] buf_waddr,
   output logic [7:0]        buf_wdata,
   output logic              frm_avail,
   output logic [SLOT_W-1:0] frm_slot,
   output logic [10:0]       frm_len,
   input  logic              frm_done,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       ovf_cnt
);

   typedef enum logic [2:0] {
      IDLE, RECV, WAIT, OVF, WAIT_OVF, ACK
   } state_t;

   localparam logic [SLOT_W:0]   CNT_FULL = (SLOT_W+1)'(P_SLOTS);
   localparam logic [SLOT_W:0]   CNT_ONE  = (SLOT_W+1)'(1);
   localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);
   localparam logic [10:0]       MIN_LEN  = 11'(P_MIN_LEN);
   localparam logic [7:0]        WIN_LAST = 8'(P_VLD_WIN - 1);

   state_t              state_q, state_d;
   logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
   logic [SLOT_W-1:0]   rd_slot_q, rd_slot_d;
   logic [SLOT_W:0]     count_q, count_d;
   logic [10:0]         idx_q, idx_d;
   logic                too_long_q, too_long_d;
   logic [7:0]          win_q, win_d;
   logic [15:0]         drop_cnt_q, drop_cnt_d;
   logic [15:0]         ovf_cnt_q, ovf_cnt_d;
   logic [10:0]         len_q [P_SLOTS];
   logic [10:0]         len_d [P_SLOTS];
   logic                ack_q, ack_d;
   logic                buf_we_q, buf_we_d;
   logic [SLOT_W+10:0]  buf_waddr_q, buf_waddr_d;
   logic [7:0]          buf_wdata_q, buf_wdata_d;
   logic                frm_avail_q, frm_avail_d;
   logic [SLOT_W-1:0]   frm_slot_q, frm_slot_d;
   logic [10:0]         frm_len_q, frm_len_d;

   logic start_rx, commit, rel, drop_inc, ovf_inc;

   // Next-state, buffer write, commit/release and counter logic
   always_comb begin
      state_d     = state_q;
      wr_slot_d   = wr_slot_q;
      rd_slot_d   = rd_slot_q;
      count_d     = count_q;
      idx_d       = idx_q;
      too_long_d  = too_long_q;
      win_d       = win_q;
      len_d       = len_q;
      buf_we_d    = 1'b0;
      buf_waddr_d = buf_waddr_q;
      buf_wdata_d = buf_wdata_q;
      ack_d       = ack_q & rx_frm_vld;
      start_rx    = 1'b0;
      commit      = 1'b0;
      drop_inc    = 1'b0;
      ovf_inc     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rx_sof) start_rx = 1'b1;
         end
         RECV: begin
            if (rx_sof) begin
               drop_inc   = 1'b1;
               idx_d      = '0;
               too_long_d = 1'b0;
            end else begin
               if (rx_byte_vld && !too_long_q) begin
                  buf_we_d    = 1'b1;
                  buf_waddr_d = {wr_slot_q, idx_q};
                  buf_wdata_d = rx_byte;
                  if (idx_q == 11'h7FF) too_long_d = 1'b1;
                  else                  idx_d = idx_q + 11'd1;
               end
               if (rx_eof) begin
                  state_d = WAIT;
                  win_d   = '0;
               end
            end
         end
         WAIT, WAIT_OVF: begin
            if (rx_sof) begin
               if (state_q == WAIT) drop_inc = 1'b1;
               start_rx = 1'b1;
            end else if (rx_frm_vld) begin
               ack_d   = 1'b1;
               state_d = ACK;
               if (state_q == WAIT) begin
                  if (!too_long_q && idx_q >= MIN_LEN) commit = 1'b1;
                  else                                 drop_inc = 1'b1;
               end
            end else if (win_q == WIN_LAST) begin
               if (state_q == WAIT) drop_inc = 1'b1;
               state_d = IDLE;
            end else begin
               win_d = win_q + 8'd1;
            end
         end
         OVF: begin
            if (rx_eof) begin
               state_d = WAIT_OVF;
               win_d   = '0;
            end
         end
         ACK: begin
            if (rx_sof)           start_rx = 1'b1;
            else if (!rx_frm_vld) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (start_rx) begin
         if (count_q == CNT_FULL) begin
            state_d = OVF;
            ovf_inc = 1'b1;
         end else begin
            state_d    = RECV;
            idx_d      = '0;
            too_long_d = 1'b0;
         end
      end

      rel = frm_done & frm_avail_q;

      if (commit) begin
         len_d[wr_slot_q] = idx_q - 11'd4;
         wr_slot_d        = wr_slot_q + SLOT_ONE;
      end
      if (rel) rd_slot_d = rd_slot_q + SLOT_ONE;

      if (commit && !rel)      count_d = count_q + CNT_ONE;
      else if (!commit && rel) count_d = count_q - CNT_ONE;

      drop_cnt_d = drop_cnt_q;
      if (drop_inc && drop_cnt_q != 16'hFFFF)
         drop_cnt_d = drop_cnt_q + 16'd1;
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_inc && ovf_cnt_q != 16'hFFFF)
         ovf_cnt_d = ovf_cnt_q + 16'd1;

      frm_avail_d = (count_d != '0);
      frm_slot_d  = rd_slot_d;
      frm_len_d   = len_d[rd_slot_d];
   end

   // State and output registers
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_q     <= IDLE;
         wr_slot_q   <= '0;
         rd_slot_q   <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         too_long_q  <= 1'b0;
         win_q       <= '0;
         drop_cnt_q  <= '0;
         ovf_cnt_q   <= '0;
         for (int i = 0; i < P_SLOTS; i++) len_q[i] <= '0;
         ack_q       <= 1'b0;
         buf_we_q    <= 1'b0;
         buf_waddr_q <= '0;
         buf_wdata_q <= '0;
         frm_avail_q <= 1'b0;
         frm_slot_q  <= '0;
         frm_len_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_slot_q   <= wr_slot_d;
         rd_slot_q   <= rd_slot_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         too_long_q  <= too_long_d;
         win_q       <= win_d;
         drop_cnt_q  <= drop_cnt_d;
         ovf_cnt_q   <= ovf_cnt_d;
         len_q       <= len_d;
         ack_q       <= ack_d;
         buf_we_q    <= buf_we_d;
         buf_waddr_q <= buf_waddr_d;
         buf_wdata_q <= buf_wdata_d;
         frm_avail_q <= frm_avail_d;
         frm_slot_q  <= frm_slot_d;
         frm_len_q   <= frm_len_d;
      end
   end

   assign rx_frm_ack = ack_q;
   assign buf_we     = buf_we_q;
   assign buf_waddr  = buf_waddr_q;
   assign buf_wdata  = buf_wdata_q;
   assign frm_avail  = frm_avail_q;
   assign frm_slot   = frm_slot_q;
   assign frm_len    = frm_len_q;
   assign drop_cnt   = drop_cnt_q;
   assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Bench for eth_rx_frame_ctrl: frame table plus hand-written corner sequences.
// Buffer writes are checked byte by byte against a generated pattern.
module tb_eth_rx_frame_ctrl;

   logic        rx_clk = 1'b0;
   logic        rx_rst_n = 1'b0;
   logic        rx_sof = 1'b0;
   logic        rx_eof = 1'b0;
   logic        rx_byte_vld = 1'b0;
   logic [7:0]  rx_byte = '0;
   logic        rx_frm_vld = 1'b0;
   logic        rx_frm_ack;
   logic        buf_we;
   logic [12:0] buf_waddr;
   logic [7:0]  buf_wdata;
   logic        frm_avail;
   logic [1:0]  frm_slot;
   logic [10:0] frm_len;
   logic        frm_done = 1'b0;
   logic [15:0] drop_cnt;
   logic [15:0] ovf_cnt;

   eth_rx_frame_ctrl dut (
      .rx_clk      (rx_clk),
      .rx_rst_n    (rx_rst_n),
      .rx_sof      (rx_sof),
      .rx_eof      (rx_eof),
      .rx_byte_vld (rx_byte_vld),
      .rx_byte     (rx_byte),
      .rx_frm_vld  (rx_frm_vld),
      .rx_frm_ack  (rx_frm_ack),
      .buf_we      (buf_we),
      .buf_waddr   (buf_waddr),
      .buf_wdata   (buf_wdata),
      .frm_avail   (frm_avail),
      .frm_slot    (frm_slot),
      .frm_len     (frm_len),
      .frm_done    (frm_done),
      .drop_cnt    (drop_cnt),
      .ovf_cnt     (ovf_cnt)
   );

   always #5 rx_clk = ~rx_clk;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int wr_err = 0;
   int exp_slot = 0;
   int seed = 0;

   typedef struct {
      int len;
      int vdly;
      int done;
      int wslot;
      int writes;
      int ack;
      int drop;
      int ovf;
      int avail;
      int fslot;
      int flen;
   } vec_t;

   vec_t tbl[10];

   function automatic logic [7:0] gen(input int s, input int i);
      return 8'(s * 29 + i * 3 + (i >> 8));
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Write scoreboard: each write must hit the expected slot, in order
   always @(negedge rx_clk) begin
      if (rx_rst_n && buf_we) begin
         if (buf_waddr != {2'(exp_slot), 11'(wr_cnt)} ||
             buf_wdata != gen(seed, wr_cnt))
            wr_err++;
         wr_cnt++;
      end
   end

   task automatic tick;
      @(posedge rx_clk);
      #1;
   endtask

   task automatic send_body(input int len, input int sd, input int slot);
      seed = sd;
      exp_slot = slot;
      wr_cnt = 0;
      wr_err = 0;
      rx_sof = 1'b1;
      tick;
      rx_sof = 1'b0;
      for (int i = 0; i < len; i++) begin
         rx_byte_vld = 1'b1;
         rx_byte = gen(sd, i);
         tick;
      end
      rx_byte_vld = 1'b0;
      rx_byte = '0;
      rx_eof = 1'b1;
      tick;
      rx_eof = 1'b0;
   endtask

   task automatic send_frame(input int len, input int vdly, input int sd,
                             input int slot, output int acked);
      acked = 0;
      send_body(len, sd, slot);
      if (vdly < 0) begin
         repeat (12) tick;
      end else begin
         repeat (vdly) tick;
         rx_frm_vld = 1'b1;
         for (int k = 0; k < 16 && acked == 0; k++) begin
            tick;
            if (rx_frm_ack) acked = 1;
         end
         repeat (2) tick;
         rx_frm_vld = 1'b0;
         repeat (3) tick;
      end
   endtask

   task automatic pulse_done;
      frm_done = 1'b1;
      tick;
      frm_done = 1'b0;
      tick;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      tbl[0] = '{100,  2, 1, 0, 100, 1, 0, 0, 1, 0, 96};
      tbl[1] = '{100, -1, 0, 1, 100, 0, 1, 0, 0, 1,  0};
      tbl[2] = '{100,  0, 0, 1, 100, 1, 1, 0, 1, 1, 96};
      tbl[3] = '{ 40,  2, 0, 2,  40, 1, 2, 0, 1, 1, 96};
      tbl[4] = '{ 64,  1, 0, 2,  64, 1, 2, 0, 1, 1, 96};
      tbl[5] = '{ 63,  1, 0, 3,  63, 1, 3, 0, 1, 1, 96};
      tbl[6] = '{ 70,  7, 0, 3,  70, 1, 3, 0, 1, 1, 96};
      tbl[7] = '{ 80,  3, 0, 0,  80, 1, 3, 0, 1, 1, 96};
      tbl[8] = '{ 90,  2, 1, 0,   0, 1, 3, 1, 1, 1, 96};
      tbl[9] = '{ 72,  2, 0, 1,  72, 1, 3, 1, 1, 2, 60};

      repeat (3) tick;
      chk("rst_avail", frm_avail, 0);
      chk("rst_ack", rx_frm_ack, 0);
      chk("rst_we", buf_we, 0);
      chk("rst_slot", frm_slot, 0);
      chk("rst_len", frm_len, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_ovf", ovf_cnt, 0);
      rx_rst_n = 1'b1;
      tick;

      for (int r = 0; r < 10; r++) begin
         send_frame(tbl[r].len, tbl[r].vdly, r + 1, tbl[r].wslot, a);
         chk($sformatf("r%0d_writes", r), wr_cnt, tbl[r].writes);
         chk($sformatf("r%0d_wrdata", r), wr_err, 0);
         chk($sformatf("r%0d_acked", r), a, tbl[r].ack);
         chk($sformatf("r%0d_ackoff", r), rx_frm_ack, 0);
         chk($sformatf("r%0d_drop", r), drop_cnt, tbl[r].drop);
         chk($sformatf("r%0d_ovf", r), ovf_cnt, tbl[r].ovf);
         chk($sformatf("r%0d_avail", r), frm_avail, tbl[r].avail);
         chk($sformatf("r%0d_fslot", r), frm_slot, tbl[r].fslot);
         chk($sformatf("r%0d_flen", r), frm_len, tbl[r].flen);
         if (tbl[r].done != 0) pulse_done;
      end

      pulse_done;
      chk("rel_fslot", frm_slot, 3);
      chk("rel_flen", frm_len, 66);

      send_frame(2100, 2, 11, 2, a);
      chk("long_writes", wr_cnt, 2048);
      chk("long_wrdata", wr_err, 0);
      chk("long_acked", a, 1);
      chk("long_drop", drop_cnt, 4);
      chk("long_avail", frm_avail, 1);
      chk("long_fslot", frm_slot, 3);

      send_body(100, 12, 2);
      tick;
      rx_frm_vld = 1'b1;
      frm_done = 1'b1;
      tick;
      frm_done = 1'b0;
      chk("co_ack", rx_frm_ack, 1);
      chk("co_avail", frm_avail, 1);
      chk("co_fslot", frm_slot, 0);
      chk("co_flen", frm_len, 76);
      repeat (2) tick;
      rx_frm_vld = 1'b0;
      repeat (3) tick;
      chk("co_writes", wr_cnt, 100);
      chk("co_drop", drop_cnt, 4);
      pulse_done;
      chk("co_fslot1", frm_slot, 1);
      chk("co_flen1", frm_len, 68);
      pulse_done;
      chk("co_fslot2", frm_slot, 2);
      chk("co_flen2", frm_len, 96);
      chk("co_avail2", frm_avail, 1);
      pulse_done;
      chk("co_empty", frm_avail, 0);

      send_frame(70, 2, 13, 3, a);
      send_frame(80, 2, 14, 0, a);
      chk("pre_avail", frm_avail, 1);
      chk("pre_fslot", frm_slot, 3);
      chk("pre_flen", frm_len, 66);

      seed = 15;
      exp_slot = 1;
      wr_cnt = 0;
      rx_sof = 1'b1;
      tick;
      rx_sof = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rx_byte_vld = 1'b1;
         rx_byte = gen(15, i);
         tick;
      end
      rx_byte_vld = 1'b0;
      rx_rst_n = 1'b0;
      #1;
      chk("mr_avail", frm_avail, 0);
      chk("mr_fslot", frm_slot, 0);
      chk("mr_flen", frm_len, 0);
      chk("mr_we", buf_we, 0);
      chk("mr_waddr", buf_waddr, 0);
      chk("mr_wdata", buf_wdata, 0);
      chk("mr_ack", rx_frm_ack, 0);
      chk("mr_drop", drop_cnt, 0);
      chk("mr_ovf", ovf_cnt, 0);
      repeat (2) tick;
      rx_rst_n = 1'b1;
      tick;

      send_frame(100, 2, 16, 0, a);
      chk("post_writes", wr_cnt, 100);
      chk("post_wrdata", wr_err, 0);
      chk("post_avail", frm_avail, 1);
      chk("post_fslot", frm_slot, 0);
      chk("post_flen", frm_len, 96);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
